branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 fetch_valid  input  1  a fetch PC is presented this cycle.
REQ-005 fetch_pc  input  32  PC of the instruction being fetched.
REQ-006 pred_valid  output  1  predict1/predict2/pprediction are valid this cycle.
REQ-007 predict1  output  1  bimodal component prediction (1 = taken).
REQ-008 predict2  output  1  gshare component prediction (1 = taken).
REQ-009 pprediction  output  1  final chooser-selected prediction.
REQ-010 upd_valid  input  1  a resolved instruction is presented for training.
REQ-011 upd_pc  input  32  PC of the resolved instruction.
REQ-012 upd_inst  input  32  resolved instruction word.
REQ-013 PCsel  input  1  actual branch outcome (1 = taken).
REQ-014 taken1, taken2  input  1 each  1 = predict1 / predict2 was correct for this branch.
REQ-015 true  input  1  1 = pprediction was correct for this branch.
REQ-016 br_count  output  16  number of trained conditional branches.
REQ-017 miss_count  output  16  number of final mispredictions.

Function
REQ-018 Tables SHALL be 16 entries each of 2-bit saturating counters: BHT (bimodal), PHT (gshare), CHT (chooser); plus a 4-bit global history register GHR.
REQ-019 Fetch indexes SHALL be bidx = fetch_pc[5:2], gidx = fetch_pc[5:2] XOR GHR, cidx = fetch_pc[5:2].
REQ-020 Prediction latency SHALL be one cycle: on a clk edge with fetch_valid=1, pred_valid<=1 and predict1<=BHT[bidx][1], predict2<=PHT[gidx][1], pprediction<=(CHT[cidx][1] ? predict2 value : predict1 value); with fetch_valid=0, pred_valid<=0 and prediction outputs hold.
REQ-021 A training event SHALL occur only when upd_valid=1 and upd_inst[6:0]=7'b1100011; all other updates are ignored with no state change.
REQ-022 On a training event, indexes SHALL use upd_pc[5:2] and the GHR value before this edge.
REQ-023 BHT[bidx] and PHT[gidx] SHALL increment if PCsel=1, decrement if PCsel=0, saturating at 2'b11 and 2'b00.
REQ-024 CHT[cidx] SHALL increment when taken2=1 and taken1=0, decrement when taken1=1 and taken2=0, hold otherwise; saturating.
REQ-025 GHR SHALL shift left by one with PCsel entering bit 0 on each training event.
REQ-026 br_count SHALL increment on each training event; miss_count SHALL increment on a training event with true=0; both saturate at 16'hFFFF.
REQ-027 Simultaneous fetch and training in one cycle SHALL both take effect; the prediction SHALL use pre-edge table and GHR values (no bypass).
REQ-028 Tables, GHR and counters SHALL update only on the rising edge of clk.

Reset
REQ-029 With rst=1 at a clk edge: BHT and PHT entries <=2'b01, CHT entries <=2'b10, GHR<=4'b0000, pred_valid/predict1/predict2/pprediction<=0, br_count/miss_count<=0.
REQ-030 rst SHALL override fetch and training in the same cycle; assertion mid-operation discards all learned state.

Verification
REQ-031 Reset, then fetch 0x00000010 -> next cycle pred_valid=1, predict1=0, predict2=0, pprediction=0.
REQ-032 Two training events at upd_pc=0x10, upd_inst[6:0]=1100011, PCsel=1, taken1=0, taken2=0, true=0 -> BHT[4]=2'b11, GHR=4'b0011, br_count=2, miss_count=2; a fetch of 0x10 then gives predict1=1.
REQ-033 Four taken training events to the same entry -> BHT saturates at 2'b11; four not-taken events -> 2'b00, never wraps.
REQ-034 Training with taken1=1, taken2=0 twice at PC 0x20 -> CHT[8]=2'b00; next fetch of 0x20 gives pprediction equal to predict1.
REQ-035 upd_valid=1 with upd_inst[6:0]=7'b0110011 -> no change to any table, GHR, br_count, miss_count.
REQ-036 Fetch and training to the same index in one cycle -> prediction reflects pre-update counter; rst asserted together with upd_valid -> all state at reset values.

Source files
------------

// File: rtl/branch_predictor.sv
// Tournament branch predictor: bimodal (BHT) + gshare (PHT) with a chooser table (CHT).
// Latency: one cycle from fetch_valid to pred_valid; training takes effect at the same edge.
// Backpressure: none; a fetch or update can be accepted every cycle, and both can occur together.
module branch_predictor (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        predict1,
  output logic        predict2,
  output logic        pprediction,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_inst,
  input  logic        PCsel,
  input  logic        taken1,
  input  logic        taken2,
  input  logic        true,
  output logic [15:0] br_count,
  output logic [15:0] miss_count
);

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [1:0]  BHT_INIT   = 2'b01;
  localparam logic [1:0]  PHT_INIT   = 2'b01;
  localparam logic [1:0]  CHT_INIT   = 2'b10;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  // Saturating 2-bit counter helpers shared by all three tables.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Architectural state
  logic [1:0]  r_bht [16];
  logic [1:0]  r_pht [16];
  logic [1:0]  r_cht [16];
  logic [3:0]  r_ghr;
  logic        r_pred_valid;
  logic        r_predict1;
  logic        r_predict2;
  logic        r_pprediction;
  logic [15:0] r_br_count;
  logic [15:0] r_miss_count;

  // Fetch-side lookup
  logic [3:0]  w_f_bidx;
  logic [3:0]  w_f_gidx;
  logic [3:0]  w_f_cidx;
  logic        w_f_p1;
  logic        w_f_p2;
  logic        w_f_pp;

  // Training-side update
  logic        w_train;
  logic [3:0]  w_u_bidx;
  logic [3:0]  w_u_gidx;
  logic [3:0]  w_u_cidx;
  logic [1:0]  w_bht_nxt;
  logic [1:0]  w_pht_nxt;
  logic [1:0]  w_cht_nxt;
  logic [3:0]  w_ghr_nxt;
  logic [15:0] w_br_nxt;
  logic [15:0] w_miss_nxt;

  // PC alignment bits and upper bits never reach the 16-entry tables.
  logic        w_unused;
  assign w_unused = ^{fetch_pc[31:6], fetch_pc[1:0], upd_pc[31:6], upd_pc[1:0], upd_inst[31:7]};

  // Fetch indexes: bimodal and chooser by PC, gshare by PC xor history.
  assign w_f_bidx = fetch_pc[5:2];
  assign w_f_gidx = fetch_pc[5:2] ^ r_ghr;
  assign w_f_cidx = fetch_pc[5:2];

  // Prediction bits read from pre-edge table contents (no bypass from training).
  always_comb begin
    w_f_p1 = r_bht[w_f_bidx][1];
    w_f_p2 = r_pht[w_f_gidx][1];
    w_f_pp = r_cht[w_f_cidx][1] ? w_f_p2 : w_f_p1;
  end

  // Only resolved conditional branches train the predictor.
  assign w_train  = upd_valid && (upd_inst[6:0] == OPC_BRANCH);
  assign w_u_bidx = upd_pc[5:2];
  assign w_u_gidx = upd_pc[5:2] ^ r_ghr;
  assign w_u_cidx = upd_pc[5:2];

  // Next counter values for the direction tables, steered by the actual outcome.
  always_comb begin
    w_bht_nxt = r_bht[w_u_bidx];
    w_pht_nxt = r_pht[w_u_gidx];
    if (PCsel) begin
      w_bht_nxt = sat_inc(r_bht[w_u_bidx]);
      w_pht_nxt = sat_inc(r_pht[w_u_gidx]);
    end else begin
      w_bht_nxt = sat_dec(r_bht[w_u_bidx]);
      w_pht_nxt = sat_dec(r_pht[w_u_gidx]);
    end
  end

  // Chooser moves toward whichever component alone was right; ties hold.
  always_comb begin
    w_cht_nxt = r_cht[w_u_cidx];
    case ({taken2, taken1})
      2'b10:   w_cht_nxt = sat_inc(r_cht[w_u_cidx]);
      2'b01:   w_cht_nxt = sat_dec(r_cht[w_u_cidx]);
      default: w_cht_nxt = r_cht[w_u_cidx];
    endcase
  end

  // History shift and saturating statistics counters.
  always_comb begin
    w_ghr_nxt  = {r_ghr[2:0], PCsel};
    w_br_nxt   = (r_br_count == CNT_MAX) ? r_br_count : r_br_count + 16'd1;
    w_miss_nxt = r_miss_count;
    if (!true) begin
      w_miss_nxt = (r_miss_count == CNT_MAX) ? r_miss_count : r_miss_count + 16'd1;
    end
  end

  // Prediction output registers; outputs hold when no fetch is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid  <= 1'b0;
      r_predict1    <= 1'b0;
      r_predict2    <= 1'b0;
      r_pprediction <= 1'b0;
    end else begin
      r_pred_valid <= fetch_valid;
      if (fetch_valid) begin
        r_predict1    <= w_f_p1;
        r_predict2    <= w_f_p2;
        r_pprediction <= w_f_pp;
      end
    end
  end

  // Table training; reset restores weakly-not-taken directions and a gshare-leaning chooser.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_bht[i] <= BHT_INIT;
        r_pht[i] <= PHT_INIT;
        r_cht[i] <= CHT_INIT;
      end
    end else if (w_train) begin
      r_bht[w_u_bidx] <= w_bht_nxt;
      r_pht[w_u_gidx] <= w_pht_nxt;
      r_cht[w_u_cidx] <= w_cht_nxt;
    end
  end

  // Global history and branch/miss statistics advance once per training event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr        <= 4'b0000;
      r_br_count   <= 16'd0;
      r_miss_count <= 16'd0;
    end else if (w_train) begin
      r_ghr        <= w_ghr_nxt;
      r_br_count   <= w_br_nxt;
      r_miss_count <= w_miss_nxt;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign predict1    = r_predict1;
  assign predict2    = r_predict2;
  assign pprediction = r_pprediction;
  assign br_count    = r_br_count;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random bench for branch_predictor against an arithmetic reference model.
// Latency: expectations are pushed at drive time and popped one cycle later by the monitor.
// Backpressure: not applicable; the design accepts every cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        predict1;
  logic        predict2;
  logic        pprediction;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_inst;
  logic        PCsel;
  logic        taken1;
  logic        taken2;
  logic        true;
  logic [15:0] br_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_valid  (pred_valid),
    .predict1    (predict1),
    .predict2    (predict2),
    .pprediction (pprediction),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_inst    (upd_inst),
    .PCsel       (PCsel),
    .taken1      (taken1),
    .taken2      (taken2),
    .true        (true),
    .br_count    (br_count),
    .miss_count  (miss_count)
  );

  typedef struct packed {
    logic        vld;
    logic        p1;
    logic        p2;
    logic        pp;
    logic [15:0] br;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counters held as plain integers in 0..3.
  int m_bht[16];
  int m_pht[16];
  int m_cht[16];
  int m_ghr;
  int m_br;
  int m_miss;
  bit m_vld, m_p1, m_p2, m_pp;

  localparam logic [31:0] BR_INST  = 32'h0000_0063;
  localparam logic [31:0] ALU_INST = 32'h0000_0033;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_bht[i] = 1;
      m_pht[i] = 1;
      m_cht[i] = 2;
    end
    m_ghr  = 0;
    m_br   = 0;
    m_miss = 0;
    m_vld  = 0;
    m_p1   = 0;
    m_p2   = 0;
    m_pp   = 0;
  endtask

  function automatic int bump(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  // Drive one cycle of stimulus and record what the outputs must be after the edge.
  task automatic step(input bit r, input bit fv, input logic [31:0] fpc,
                      input bit uv, input logic [31:0] upc, input logic [31:0] uinst,
                      input bit pc, input bit t1, input bit t2, input bit tr);
    exp_t e;
    int   fi, ui, ugi;
    @(negedge clk);
    #1;
    rst = r; fetch_valid = fv; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_inst = uinst;
    PCsel = pc; taken1 = t1; taken2 = t2; true = tr;
    if (r) begin
      model_reset();
    end else begin
      fi = int'(fpc[5:2]);
      m_vld = fv;
      if (fv) begin
        m_p1 = (m_bht[fi] >= 2);
        m_p2 = (m_pht[fi ^ m_ghr] >= 2);
        m_pp = (m_cht[fi] >= 2) ? m_p2 : m_p1;
      end
      if (uv && uinst[6:0] == 7'b1100011) begin
        ui  = int'(upc[5:2]);
        ugi = ui ^ m_ghr;
        m_bht[ui]  = bump(m_bht[ui], pc);
        m_pht[ugi] = bump(m_pht[ugi], pc);
        if (t2 && !t1) m_cht[ui] = bump(m_cht[ui], 1'b1);
        if (t1 && !t2) m_cht[ui] = bump(m_cht[ui], 1'b0);
        m_ghr = ((m_ghr * 2) + int'(pc)) % 16;
        if (m_br < 65535) m_br = m_br + 1;
        if (!tr && m_miss < 65535) m_miss = m_miss + 1;
      end
    end
    e.vld  = m_vld;
    e.p1   = m_p1;
    e.p2   = m_p2;
    e.pp   = m_pp;
    e.br   = 16'(m_br);
    e.miss = 16'(m_miss);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
  endtask

  task automatic train(input logic [31:0] pc_v, input logic [31:0] inst,
                       input bit pc, input bit t1, input bit t2, input bit tr);
    step(0, 0, 32'h0, 1, pc_v, inst, pc, t1, t2, tr);
  endtask

  task automatic fetch(input logic [31:0] pc_v);
    step(0, 1, pc_v, 0, 32'h0, 32'h0, 0, 0, 0, 1);
  endtask

  // Monitor: one expectation per driven cycle, compared a half cycle after the edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pred_valid, predict1, predict2, pprediction, br_count, miss_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t act vld=%b p1=%b p2=%b pp=%b br=%0d miss=%0d req vld=%b p1=%b p2=%b pp=%b br=%0d miss=%0d",
                   $time, a.vld, a.p1, a.p2, a.pp, a.br, a.miss,
                   e.vld, e.p1, e.p2, e.pp, e.br, e.miss);
        end
      end
    end
  end

  initial begin
    logic [31:0] fpc, upc, uinst;
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_inst = '0; PCsel = 1'b0; taken1 = 1'b0; taken2 = 1'b0; true = 1'b1;
    model_reset();

    // Reset state and first prediction after reset
    step(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    step(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    fetch(32'h0000_0010);
    idle();

    // Two taken branches at 0x10 with final mispredict, then re-fetch
    train(32'h10, BR_INST, 1, 0, 0, 0);
    train(32'h10, BR_INST, 1, 0, 0, 0);
    fetch(32'h0000_0010);

    // Saturation up and down on one bimodal entry
    for (int i = 0; i < 4; i++) train(32'h30, BR_INST, 1, 0, 1, 1);
    fetch(32'h0000_0030);
    for (int i = 0; i < 4; i++) train(32'h30, BR_INST, 0, 1, 0, 1);
    fetch(32'h0000_0030);

    // Chooser pushed toward bimodal at 0x20
    train(32'h20, BR_INST, 1, 1, 0, 1);
    train(32'h20, BR_INST, 1, 1, 0, 1);
    fetch(32'h0000_0020);

    // Non-branch opcode must not train
    train(32'h10, ALU_INST, 0, 0, 0, 0);
    fetch(32'h0000_0010);

    // Fetch and training on the same entry in one cycle, then the updated view
    step(0, 1, 32'h10, 1, 32'h10, BR_INST, 0, 0, 0, 0);
    step(0, 1, 32'h10, 1, 32'h10, BR_INST, 0, 0, 0, 0);
    fetch(32'h0000_0010);

    // Reset together with fetch and training discards everything
    step(1, 1, 32'h10, 1, 32'h10, BR_INST, 1, 0, 1, 0);
    fetch(32'h0000_0010);

    // Randomized traffic over a small PC window so saturation is frequent
    for (int n = 0; n < 3000; n++) begin
      fpc = {26'($urandom), 4'($urandom), 2'b00};
      upc = {26'($urandom), 4'($urandom_range(0, 5)), 2'b00};
      uinst = $urandom;
      if ($urandom_range(0, 3) != 0) uinst[6:0] = 7'b1100011;
      step(($urandom_range(0, 199) == 0), 1'($urandom), fpc,
           1'($urandom), upc, uinst,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain act pending=%0d req pending=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
